// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with
// req/ready memory handshakes, per-access timeout and a retired-instruction counter.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write_en,
  output logic             mem_to_reg_en,
  output logic             link_en,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;
  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LD = 3'd2, C_ST = 3'd3, C_JAL = 3'd4,
                         C_BR = 3'd5, C_BAD = 3'd6;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [2:0] state_q, state_d, cls_q, cls_d, dec_cls;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic req, rdy, timeout, retire;
  always_comb
    dec_cls = opcode == 7'b0110011 ? C_R :
              opcode == 7'b0010011 ? C_I :
              opcode == 7'b0000011 ? C_LD :
              opcode == 7'b0100011 ? C_ST :
              opcode == 7'b1101111 ? C_JAL :
              opcode == 7'b1100011 ? C_BR : C_BAD;
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'b00;
    alu_src = 1'b0;
    alu_op = 2'b00;
    reg_write_en = 1'b0;
    mem_to_reg_en = 1'b0;
    link_en = 1'b0;
    illegal_instr = 1'b0;
    bus_error = 1'b0;
    retire = 1'b0;
    state_d = state_q;
    cls_d = cls_q;
    req = state_q == FETCH || state_q == MEM;
    rdy = state_q == FETCH ? imem_ready : dmem_ready;
    // ready on the final allowed cycle wins over the timeout
    timeout = req && !rdy && TIMEOUT_CYCLES != 0 && wait_q == WW'(TIMEOUT_CYCLES - 1);
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        state_d = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        cls_d = dec_cls;
        illegal_instr = dec_cls == C_BAD;
        pc_write = dec_cls == C_BAD;
        state_d = dec_cls == C_BAD ? FETCH : EXEC;
      end
      EXEC: begin
        alu_src = cls_q inside {C_I, C_LD, C_ST};
        alu_op = cls_q == C_BR ? 2'b01 : cls_q inside {C_R, C_I} ? 2'b10 : 2'b00;
        pc_write = cls_q == C_BR;
        pc_src = cls_q == C_BR ? {1'b0, branch_taken} : 2'b00;
        retire = cls_q == C_BR;
        state_d = cls_q == C_BR ? FETCH : cls_q inside {C_LD, C_ST} ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = cls_q == C_ST;
        pc_write = dmem_ready && cls_q == C_ST;
        retire = dmem_ready && cls_q == C_ST;
        state_d = !dmem_ready ? MEM : cls_q == C_ST ? FETCH : WB;
      end
      WB: begin
        reg_write_en = 1'b1;
        pc_write = 1'b1;
        retire = 1'b1;
        mem_to_reg_en = cls_q == C_LD;
        link_en = cls_q == C_JAL;
        pc_src = cls_q == C_JAL ? 2'b10 : 2'b00;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (timeout) begin
      bus_error = 1'b1;
      state_d = FETCH;
    end
    wait_d = (state_d != state_q || timeout) ? '0 : req && !rdy ? wait_q + WW'(1) : wait_q;
    instret_d = instret_q + CNT_W'(retire);
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src = 2'b00;
      alu_src = 1'b0;
      alu_op = 2'b00;
      reg_write_en = 1'b0;
      mem_to_reg_en = 1'b0;
      link_en = 1'b0;
      illegal_instr = 1'b0;
      bus_error = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cls_q <= C_R;
      wait_q <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      wait_q <= wait_d;
      instret_q <= instret_d;
    end
  end
  assign state = state_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: builds expected per-cycle traces from the instruction
// sequencing rules and compares the controller against them.
module tb_multicycle_controller;
  localparam int T = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011,
                         OP_BAD = 7'b1111111;
  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src;
    logic alu_src;
    logic [1:0] alu_op;
    logic reg_write_en, mem_to_reg_en, link_en, illegal_instr, bus_error;
    logic [2:0] state;
  } out_t;
  typedef struct packed {
    logic [6:0] op;
    logic ir, dr, bt;
    out_t o;
    logic [3:0] ret;
  } cyc_t;
  logic clk = 1'b0, reset = 1'b1, branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [6:0] opcode = OP_R;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src, reg_write_en;
  logic mem_to_reg_en, link_en, illegal_instr, bus_error;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;
  logic [3:0] instret;
  out_t obs;
  cyc_t q[$];
  cyc_t c;
  logic [3:0] ret;
  logic [6:0] cur_op;
  int tests = 0, fails = 0;
  multicycle_controller #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .reg_write_en(reg_write_en),
    .mem_to_reg_en(mem_to_reg_en), .link_en(link_en), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  assign obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
                reg_write_en, mem_to_reg_en, link_en, illegal_instr, bus_error, state};

  task automatic add(input out_t o, input logic ir, input logic dr, input logic bt);
    q.push_back('{cur_op, ir, dr, bt, o, ret});
  endtask

  // iw/dw = not-ready cycles before ready; >= T means the access times out
  task automatic gen(input logic [6:0] op, input int iw, input int dw, input logic bt);
    out_t o;
    logic legal, ld, st, br, jal;
    cur_op = op;
    legal = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_BR};
    ld = op == OP_LD; st = op == OP_ST; br = op == OP_BR; jal = op == OP_JAL;
    for (int i = 0; i < T; i++) begin
      o = '0; o.imem_req = 1'b1; o.ir_write = i == iw; o.bus_error = i == T - 1 && iw > i;
      add(o, i == iw, 1'($urandom), 1'($urandom));
      if (i == iw) break;
    end
    if (iw >= T) return;
    o = '0; o.state = 3'd1; o.illegal_instr = !legal; o.pc_write = !legal;
    add(o, 1'($urandom), 1'($urandom), 1'($urandom));
    if (!legal) return;
    o = '0; o.state = 3'd2;
    if (br) begin
      o.alu_op = 2'b01; o.pc_write = 1'b1; o.pc_src = {1'b0, bt};
      add(o, 1'($urandom), 1'($urandom), bt);
      ret++;
      return;
    end
    o.alu_src = op inside {OP_I, OP_LD, OP_ST};
    o.alu_op = op inside {OP_R, OP_I} ? 2'b10 : 2'b00;
    add(o, 1'($urandom), 1'($urandom), 1'($urandom));
    if (ld || st) begin
      for (int i = 0; i < T; i++) begin
        o = '0; o.state = 3'd3; o.dmem_req = 1'b1; o.dmem_we = st;
        o.pc_write = st && i == dw; o.bus_error = i == T - 1 && dw > i;
        add(o, 1'($urandom), i == dw, 1'($urandom));
        if (i == dw) break;
      end
      if (dw >= T) return;
      if (st) begin ret++; return; end
    end
    o = '0; o.state = 3'd4; o.reg_write_en = 1'b1; o.pc_write = 1'b1;
    o.mem_to_reg_en = ld; o.link_en = jal; o.pc_src = jal ? 2'b10 : 2'b00;
    add(o, 1'($urandom), 1'($urandom), 1'($urandom));
    ret++;
  endtask

  task automatic step(input cyc_t s);
    opcode = s.op; imem_ready = s.ir; dmem_ready = s.dr; branch_taken = s.bt;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (obs !== '0 || instret !== 4'd0) begin
      fails++; $display("FAIL reset: out=%h instret=%0d, want out=0 instret=0", obs, instret);
    end
    @(negedge clk);
    reset = 1'b0; ret = '0;
  endtask

  task automatic test_rtype;
    gen(OP_R, 1, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL rtype: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    #1; tests++;
    if (instret !== 4'd1) begin fails++; $display("FAIL rtype_instret: got %0d want 1", instret); end
  endtask

  task automatic test_load;
    int reqs = 0;
    logic [3:0] start = ret;
    gen(OP_LD, 0, 2, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      reqs += int'(dmem_req);
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL load: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    #1; tests++;
    if (reqs != 3 || instret !== start + 4'd1) begin
      fails++; $display("FAIL load_lat: dmem_req cycles=%0d instret=%0d, want 3 and %0d", reqs, instret, start + 4'd1);
    end
  endtask

  task automatic test_branch;
    gen(OP_BR, 0, 0, 1'b1);
    gen(OP_BR, 2, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL branch: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal_store;
    int wr = 0;
    gen(OP_JAL, 0, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL jal: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    gen(OP_ST, 0, 1, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      wr += int'(reg_write_en);
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL store: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    tests++;
    if (wr != 0) begin fails++; $display("FAIL store_regwrite: got %0d cycles want 0", wr); end
  endtask

  task automatic test_illegal;
    logic [3:0] start = ret;
    gen(OP_BAD, 0, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL illegal: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    #1; tests++;
    if (instret !== start) begin fails++; $display("FAIL illegal_instret: got %0d want %0d", instret, start); end
  endtask

  task automatic test_timeout;
    gen(OP_R, T, 0, 1'b0);
    gen(OP_R, T - 1, 0, 1'b0);
    gen(OP_LD, 0, T, 1'b0);
    gen(OP_ST, 1, T - 1, 1'b0);
    gen(OP_I, T + 2, 0, 1'b0);
    gen(OP_I, 0, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL timeout: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops [7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_BR, OP_BAD};
    for (int n = 0; n < 60; n++)
      gen(ops[$urandom_range(0, 6)], $urandom_range(0, T), $urandom_range(0, T), 1'($urandom));
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL back_to_back: op=%b out=%h instret=%0d, want out=%h instret=%0d", c.op, obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem;
    out_t e;
    gen(OP_LD, 0, T, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL mid_mem_pre: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
    q.delete();
    reset = 1'b1; dmem_ready = 1'b1;
    #1;
    e = '0; e.state = 3'd3; tests++;
    if (obs !== e) begin fails++; $display("FAIL mid_mem_gate: out=%h want %h", obs, e); end
    @(negedge clk);
    #1; tests++;
    if (obs !== '0 || instret !== 4'd0) begin
      fails++; $display("FAIL mid_mem_reset: out=%h instret=%0d, want out=0 instret=0", obs, instret);
    end
    reset = 1'b0; dmem_ready = 1'b0; ret = '0;
    gen(OP_R, 0, 0, 1'b0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c); tests++;
      if (obs !== c.o || instret !== c.ret) begin
        fails++; $display("FAIL mid_mem_recover: out=%h instret=%0d, want out=%h instret=%0d", obs, instret, c.o, c.ret);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_load;
    test_branch;
    test_jal_store;
    test_illegal;
    test_timeout;
    test_back_to_back;
    test_reset_mid_mem;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
